note_highway: RTL and testbench
===============================

# note_highway

Multi-note scrolling lane engine for the rhythm-game display.
- Buffers up to DEPTH note rows. Each row is a per-lane mask plus a vertical position.
- Moves all rows upward at a programmable rate.
- Answers the VGA pixel query with one sprite bit per lane.
- Resolves player presses against a hit window and reports misses when rows leave the screen.
- Sits between the pattern sequencer (pushes rows) and the top-level video mux and score logic.

## Interface
- LANES, 4: number of vertical lanes; lane width is H_RES/LANES.
- DEPTH, 8: maximum rows in flight; power of two.
- H_RES, 640: active horizontal pixels.
- Y_W, 10: width of the y position.
- SPAWN_Y, 479: y given to a newly pushed row.
- EXIT_Y, 8: a row whose y ≤ EXIT_Y on a tick is retired.
- HIT_Y, 40: centre of the hit window.
- HIT_WIN, 6: half-width of the hit window.
- HALF_H, 8: sprite half-height.
- SPEED, 1: pixels moved per tick.
- TICK_DIV, 800000: clock cycles per movement tick.

Ports:
- CLOCK_25, in, 1: system clock, 25 MHz.
- reset_n, in, 1: reset, asynchronous, active-low.
- push_valid, in, 1: new row offered.
- push_mask, in, LANES: lanes populated in the new row.
- push_ready, out, 1: high when fewer than DEPTH rows are held.
- press, in, LANES: one-cycle button press per lane.
- next_x, in, 10: pixel x being queried.
- next_y, in, Y_W: pixel y being queried.
- sprite_pattern, out, LANES: combinational sprite hit per lane.
- hit_pulse, out, LANES: registered one-cycle hit flag per lane.
- miss_pulse, out, 1: registered one-cycle flag that a row retired with unhit bits.
- row_count, out, $clog2(DEPTH)+1: rows held.

## Operation
- Storage: circular buffer (head, tail, count). Each entry holds mask[LANES] and y[Y_W].
  - Rows always move together, so head is the oldest row and has the smallest y.
- Push: accepted when push_valid && push_ready. The entry is written at tail with y = SPAWN_Y and mask = push_mask.
  - A mask of 0 is accepted and occupies a slot.
- Tick: a divider counts 0..TICK_DIV-1 and pulses `tick` when it reaches TICK_DIV-1.
  - On tick, if the head is valid and y ≤ EXIT_Y, the head retires. Only one retire per tick.
  - All other valid entries take y ← y − SPEED.
- Miss: a retiring head with any mask bit still set raises miss_pulse for one cycle.
- Hit: for each lane l with press[l] high, find the oldest valid entry with mask[l]=1 and |y − HIT_Y| ≤ HIT_WIN.
  - If one is found, clear that mask bit and raise hit_pulse[l] on the next cycle.
  - A press with no match has no effect. Lanes resolve independently in the same cycle.
- Sprite: sprite_pattern[l] is the OR over valid entries of all three conditions:
  - mask[l] is set;
  - l·H_RES/LANES ≤ next_x < (l+1)·H_RES/LANES;
  - next_y + HALF_H ≥ y and next_y < y + HALF_H.
  - Evaluate the y comparison in Y_W+1 bits; no underflow is allowed.
- Parameter legality: EXIT_Y ≥ SPEED and EXIT_Y < HIT_Y − HIT_WIN. These guarantee a retiring row is never hittable; the checks are elaboration-time.

## Timing
- Reset values:
  - buffer empty; row_count 0; push_ready 1;
  - hit_pulse 0; miss_pulse 0; tick counter 0; all masks 0.
- Push latency: an entry accepted in cycle N is visible in sprite_pattern and row_count from N+1.
- Hit latency: press in cycle N produces hit_pulse in N+1 and the cleared mask in N+1.
- Same-cycle ordering:
  - Hit uses the pre-tick y. Clear and move apply together.
  - Push and tick together: the new row enters at SPAWN_Y unmoved.
  - Push and retire together: both occur; count is unchanged. push_ready still reflects the pre-cycle count.
  - Hit and retire on the head are impossible under the parameter constraints.
- Full: push_ready = 0 while count = DEPTH. push_valid is ignored and nothing is overwritten.
- Empty tick: the counter wraps with no other effect.
- reset_n asserted mid-operation: immediate clear of all state. Pulses drop asynchronously.

## Configuration
- NOTE_HIGHWAY_SCORE_EN defined: adds output ports score (16) and misses (16), both reset 0.
  - score increments by the popcount of hit lanes each cycle.
  - misses increments by the popcount of the retiring mask.
  - Both saturate at 16'hFFFF.
- Undefined: neither port nor counter exists. All other behaviour is identical.

## Structure
- Shared package note_pkg holds:
  - the H_RES, V_RES and lane-colour constants;
  - the row entry typedef (mask + y);
  - the popcount function.
- Sub-module note_tick_gen is the TICK_DIV divider: CLOCK_25 and reset_n in, tick out. Reused by other scrolling blocks.

## Test plan
Bench parameters: DEPTH=4, TICK_DIV=4, SPAWN_Y=100, EXIT_Y=10, HIT_Y=40, HIT_WIN=4, SPEED=1.
- Push mask 4'b0101, then wait 4 ticks → y=96. Query (next_x=100, next_y=90) → sprite_pattern=4'b0001. Query x=400 → 4'b0100.
- Push 5 rows back-to-back with no ticks → push_ready drops after the 4th. The 5th is ignored and row_count=4.
- Move a row with mask 4'b0010 to y=42, then press 4'b0010 → hit_pulse=4'b0010 one cycle later. The bit is cleared, no miss at exit, and score=1 with SCORE_EN.
- Press lane 1 with the row at y=50 → no hit_pulse, and the mask is kept.
- Let a row with mask 4'b1001 reach y=10 and tick → retired, miss_pulse one cycle, misses=2 with SCORE_EN, row_count decrements.
- Push coinciding with a tick and a retire with count=2 → count stays 2. The new row holds y=100 and the other row is decremented by 1.
- Assert reset_n low mid-scroll → row_count=0, sprite_pattern=0 and push_ready=1 immediately.

Source files
------------

// File: rtl/note_pkg.sv
// Shared constants, the row entry type and a popcount helper for the note display blocks.
package note_pkg;

  localparam int H_RES_PX   = 640;
  localparam int V_RES_PX   = 480;
  localparam int NOTE_LANES = 4;
  localparam int NOTE_Y_W   = 10;

  // 12-bit RGB colours for lanes 0..3, lane 0 in the low bits.
  localparam logic [47:0] LANE_RGB = {12'h0F0, 12'hFF0, 12'h00F, 12'hF00};

  typedef struct packed {
    logic [NOTE_LANES-1:0] mask;
    logic [NOTE_Y_W-1:0]   y;
  } row_t;

  function automatic logic [4:0] popcount(input logic [NOTE_LANES-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NOTE_LANES; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/note_tick_gen.sv
// Free-running divider: tick is high for the one cycle in which the count sits at TICK_DIV-1.
module note_tick_gen #(
  parameter int TICK_DIV = 800000
) (
  input  logic CLOCK_25,
  input  logic reset_n,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/note_highway.sv
// Scrolling note-row buffer: push, tick-driven movement, hit/miss resolution and sprite query.
// Optional score/misses counters are built when NOTE_HIGHWAY_SCORE_EN is defined.
module note_highway
  import note_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int DEPTH    = 8,
  parameter int H_RES    = H_RES_PX,
  parameter int Y_W      = 10,
  parameter int SPAWN_Y  = 479,
  parameter int EXIT_Y   = 8,
  parameter int HIT_Y    = 40,
  parameter int HIT_WIN  = 6,
  parameter int HALF_H   = 8,
  parameter int SPEED    = 1,
  parameter int TICK_DIV = 800000
) (
  input  logic                     CLOCK_25,
  input  logic                     reset_n,
  input  logic                     push_valid,
  input  logic [LANES-1:0]         push_mask,
  output logic                     push_ready,
  input  logic [LANES-1:0]         press,
  input  logic [9:0]               next_x,
  input  logic [Y_W-1:0]           next_y,
  output logic [LANES-1:0]         sprite_pattern,
  output logic [LANES-1:0]         hit_pulse,
  output logic                     miss_pulse,
  output logic [$clog2(DEPTH):0]   row_count
`ifdef NOTE_HIGHWAY_SCORE_EN
  ,
  output logic [15:0]              score,
  output logic [15:0]              misses
`endif
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             LANE_W   = H_RES / LANES;
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [Y_W-1:0] SPAWN_V  = Y_W'(SPAWN_Y);
  localparam logic [Y_W-1:0] EXIT_V   = Y_W'(EXIT_Y);
  localparam logic [Y_W-1:0] WIN_LO   = Y_W'(HIT_Y - HIT_WIN);
  localparam logic [Y_W-1:0] WIN_HI   = Y_W'(HIT_Y + HIT_WIN);
  localparam logic [Y_W-1:0] SPD      = Y_W'(SPEED);
  localparam logic [Y_W:0]   HALF_W1  = (Y_W+1)'(HALF_H);

  // The exit line must sit below the hit window so a retiring row can never also be hit.
  if (EXIT_Y < SPEED || EXIT_Y >= HIT_Y - HIT_WIN) begin : g_bad_exit
    $error("note_highway: EXIT_Y must satisfy SPEED <= EXIT_Y < HIT_Y - HIT_WIN");
  end
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("note_highway: DEPTH must be a power of two >= 2");
  end
  if (LANES != NOTE_LANES || Y_W != NOTE_Y_W) begin : g_bad_row
    $error("note_highway: LANES/Y_W must match the shared row_t layout");
  end

  row_t             rows_q [DEPTH];
  row_t             rows_d [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d, hit_slot;
  logic [AW:0]      count_q, count_d;
  logic [DEPTH-1:0] valid;
  logic [LANES-1:0] hit_q, hit_d, retire_mask;
  logic             miss_q, miss_d, tick, retire, push_fire, hit_found;

  note_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLOCK_25 (CLOCK_25),
    .reset_n  (reset_n),
    .tick     (tick)
  );

  // push handshake: a row transfers on any edge where push_valid && push_ready; ready depends only on the held count.
  assign push_ready     = (count_q != CNT_FULL);
  assign row_count      = count_q;
  assign hit_pulse      = hit_q;
  assign miss_pulse     = miss_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) valid[i] = ({1'b0, AW'(i) - head_q} < count_q);
  end

  always_comb begin
    sprite_pattern = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int l = 0; l < LANES; l++) begin
        if (valid[i] && rows_q[i].mask[l]
            && int'(next_x) >= l * LANE_W && int'(next_x) < (l + 1) * LANE_W
            && ({1'b0, next_y} + HALF_W1 >= {1'b0, rows_q[i].y})
            && ({1'b0, next_y} < {1'b0, rows_q[i].y} + HALF_W1))
          sprite_pattern[l] = 1'b1;
      end
    end
  end

  always_comb begin
    rows_d    = rows_q;
    hit_d     = '0;
    hit_found = 1'b0;
    hit_slot  = '0;
    for (int l = 0; l < LANES; l++) begin
      hit_found = 1'b0;
      hit_slot  = '0;
      // Scan newest to oldest so the last match written is the oldest row.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (press[l] && ({1'b0, AW'(k)} < count_q)
            && rows_q[head_q + AW'(k)].mask[l]
            && rows_q[head_q + AW'(k)].y >= WIN_LO
            && rows_q[head_q + AW'(k)].y <= WIN_HI) begin
          hit_found = 1'b1;
          hit_slot  = head_q + AW'(k);
        end
      end
      if (hit_found) begin
        rows_d[hit_slot].mask[l] = 1'b0;
        hit_d[l]                 = 1'b1;
      end
    end

    retire      = tick && (count_q != '0) && (rows_q[head_q].y <= EXIT_V);
    retire_mask = retire ? rows_d[head_q].mask : '0;
    miss_d      = |retire_mask;
    if (tick) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && !(retire && (AW'(i) == head_q)))
          rows_d[i].y = rows_q[i].y - SPD;
      end
    end
    if (retire) rows_d[head_q].mask = '0;

    // The tail slot is never valid while ready, so the new row is written unmoved.
    push_fire = push_valid && push_ready;
    if (push_fire) begin
      rows_d[tail_q].mask = push_mask;
      rows_d[tail_q].y    = SPAWN_V;
    end
    head_d  = head_q + AW'(retire);
    tail_d  = tail_q + AW'(push_fire);
    count_d = count_q + (AW+1)'(push_fire) - (AW+1)'(retire);
  end

  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) rows_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      hit_q   <= '0;
      miss_q  <= 1'b0;
    end else begin
      rows_q  <= rows_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

`ifdef NOTE_HIGHWAY_SCORE_EN
  logic [15:0] score_q, score_d, misses_q, misses_d;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {12'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    score_d  = sat_add(score_q, popcount(hit_d));
    misses_d = sat_add(misses_q, popcount(retire_mask));
  end

  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      score_q  <= '0;
      misses_q <= '0;
    end else begin
      score_q  <= score_d;
      misses_q <= misses_d;
    end
  end

  assign score  = score_q;
  assign misses = misses_q;
`endif

endmodule

// File: tb/tb_note_highway.sv
// Self-checking bench for note_highway: queue-based reference model, sprite query table, corner sequences.
module tb_note_highway;

  localparam int LANES = 4, DEPTH = 4, H_RES = 640, Y_W = 10, SPAWN_Y = 100, EXIT_Y = 10;
  localparam int HIT_Y = 40, HIT_WIN = 4, HALF_H = 8, SPEED = 1, TICK_DIV = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             push_valid = 1'b0;
  logic [LANES-1:0] push_mask = '0;
  logic             push_ready;
  logic [LANES-1:0] press = '0;
  logic [9:0]       next_x = '0;
  logic [Y_W-1:0]   next_y = '0;
  logic [LANES-1:0] sprite_pattern, hit_pulse;
  logic             miss_pulse;
  logic [2:0]       row_count;
`ifdef NOTE_HIGHWAY_SCORE_EN
  logic [15:0]      score, misses;
`endif

  note_highway #(
    .LANES(LANES), .DEPTH(DEPTH), .H_RES(H_RES), .Y_W(Y_W), .SPAWN_Y(SPAWN_Y), .EXIT_Y(EXIT_Y),
    .HIT_Y(HIT_Y), .HIT_WIN(HIT_WIN), .HALF_H(HALF_H), .SPEED(SPEED), .TICK_DIV(TICK_DIV)
  ) dut (
    .CLOCK_25(clk), .reset_n(rst_n), .push_valid(push_valid), .push_mask(push_mask),
    .push_ready(push_ready), .press(press), .next_x(next_x), .next_y(next_y),
    .sprite_pattern(sprite_pattern), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .row_count(row_count)
`ifdef NOTE_HIGHWAY_SCORE_EN
    , .score(score), .misses(misses)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #20 clk = ~clk;

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] mask;
    int         y;
  } mrow_t;

  mrow_t      m_q[$];
  logic [4:0] exp_q[$];   // expected {hit_pulse, miss_pulse} one cycle later
  int         tcnt, exp_score, exp_misses, miss_seen;
  int         total = 0, bad = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] model_sprite(input int x, input int y);
    logic [3:0] s;
    s = '0;
    foreach (m_q[i])
      for (int l = 0; l < LANES; l++)
        if (m_q[i].mask[l] && x >= l * (H_RES / LANES) && x < (l + 1) * (H_RES / LANES)
            && y + HALF_H >= m_q[i].y && y < m_q[i].y + HALF_H)
          s[l] = 1'b1;
    return s;
  endfunction

  task automatic model_step(input logic pv, input logic [3:0] pm, input logic [3:0] pr);
    logic [3:0] h;
    logic       ms, tick, ready, found;
    mrow_t      r;
    h     = '0;
    ms    = 1'b0;
    tick  = (tcnt == TICK_DIV - 1);
    ready = (m_q.size() < DEPTH);
    for (int l = 0; l < LANES; l++) begin
      found = 1'b0;
      for (int i = 0; i < m_q.size(); i++) begin
        if (pr[l] && !found && m_q[i].mask[l]
            && m_q[i].y >= HIT_Y - HIT_WIN && m_q[i].y <= HIT_Y + HIT_WIN) begin
          r = m_q[i];
          r.mask[l] = 1'b0;
          m_q[i] = r;
          h[l] = 1'b1;
          found = 1'b1;
        end
      end
    end
    if (tick && m_q.size() > 0 && m_q[0].y <= EXIT_Y) begin
      ms = (m_q[0].mask != 0);
      exp_misses = exp_misses + $countones(m_q[0].mask);
      if (exp_misses > 65535) exp_misses = 65535;
      void'(m_q.pop_front());
    end
    if (tick)
      for (int i = 0; i < m_q.size(); i++) begin
        r = m_q[i];
        r.y = r.y - SPEED;
        m_q[i] = r;
      end
    if (pv && ready) begin
      r.mask = pm;
      r.y    = SPAWN_Y;
      m_q.push_back(r);
    end
    exp_score = exp_score + $countones(h);
    if (exp_score > 65535) exp_score = 65535;
    tcnt = tick ? 0 : tcnt + 1;
    exp_q.push_back({h, ms});
  endtask

  // ---------------- driver tasks (called and returning at a negedge) ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    push_valid = 1'b0; push_mask = '0; press = '0; next_x = '0; next_y = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_q.delete();
    exp_q.delete();
    exp_q.push_back(5'b0);
    tcnt = 0; exp_score = 0; exp_misses = 0; miss_seen = 0;
  endtask

  task automatic do_cycle(input logic pv, input logic [3:0] pm, input logic [3:0] pr,
                          input logic [9:0] x, input logic [Y_W-1:0] y);
    logic [4:0] pulses;
    push_valid = pv; push_mask = pm; press = pr; next_x = x; next_y = y;
    #1;
    pulses = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b0;
    check("sprite", int'(sprite_pattern), int'(model_sprite(int'(x), int'(y))));
    check("row_count", int'(row_count), m_q.size());
    check("push_ready", int'(push_ready), int'(m_q.size() < DEPTH));
    check("hit_pulse", int'(hit_pulse), int'(pulses[4:1]));
    check("miss_pulse", int'(miss_pulse), int'(pulses[0]));
`ifdef NOTE_HIGHWAY_SCORE_EN
    check("score", int'(score), exp_score);
    check("misses", int'(misses), exp_misses);
`endif
    if (miss_pulse === 1'b1) miss_seen++;
    model_step(pv, pm, pr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    do_cycle(1'b0, 4'b0, 4'b0, 10'($urandom_range(0, 639)), Y_W'($urandom_range(0, 110)));
  endtask

  task automatic wait_head_y(input int target);
    int n;
    n = 0;
    while (m_q.size() > 0 && m_q[0].y != target && n < 2000) begin
      idle();
      n++;
    end
    check("reach_y", (m_q.size() > 0) ? m_q[0].y : -1, target);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_q.size() > 0 && n < 2000) begin
      idle();
      n++;
    end
    idle();
  endtask

  task automatic query(input string name, input int x, input int y, input logic [3:0] exp);
    next_x = 10'(x);
    next_y = Y_W'(y);
    #1;
    check(name, int'(sprite_pattern), int'(exp));
  endtask

  // ---------------- sprite query table ----------------
  typedef struct {
    int         x;
    int         y;
    logic [3:0] exp;
  } qvec_t;

  qvec_t tbl[10];

  initial begin
    int n;
    tbl[0] = '{100,  90, 4'b0001};
    tbl[1] = '{400,  90, 4'b0100};
    tbl[2] = '{200,  90, 4'b0000};
    tbl[3] = '{500,  90, 4'b0000};
    tbl[4] = '{100,  88, 4'b0001};
    tbl[5] = '{100,  87, 4'b0000};
    tbl[6] = '{100, 103, 4'b0001};
    tbl[7] = '{100, 104, 4'b0000};
    tbl[8] = '{159,  96, 4'b0001};
    tbl[9] = '{479,  96, 4'b0100};

    // Row 0101 scrolled to y=96, then the query table.
    do_reset();
    do_cycle(1'b1, 4'b0101, 4'b0, 10'd0, 10'd0);
    wait_head_y(96);
    for (int i = 0; i < 10; i++) query("table_query", tbl[i].x, tbl[i].y, tbl[i].exp);

    // Five back-to-back pushes against DEPTH=4.
    do_reset();
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 4'(i + 1), 4'b0, 10'd100, 10'd100);
    check("full_count", int'(row_count), 4);
    check("full_ready", int'(push_ready), 0);

    // Hit inside the window, then no miss on exit.
    do_reset();
    do_cycle(1'b1, 4'b0010, 4'b0, 10'd0, 10'd0);
    wait_head_y(42);
    do_cycle(1'b0, 4'b0, 4'b0010, 10'd200, 10'd42);
    check("hit_now", int'(hit_pulse), 4'b0010);
    query("hit_cleared", 200, 42, 4'b0000);
    drain();
    check("hit_no_miss", miss_seen, 0);
`ifdef NOTE_HIGHWAY_SCORE_EN
    check("hit_score", int'(score), 1);
`endif

    // Press outside the window.
    do_reset();
    do_cycle(1'b1, 4'b0010, 4'b0, 10'd0, 10'd0);
    wait_head_y(50);
    do_cycle(1'b0, 4'b0, 4'b0010, 10'd200, 10'd50);
    check("nohit_pulse", int'(hit_pulse), 0);
    query("nohit_kept", 200, 50, 4'b0010);

    // Unhit row 1001 retires as a miss.
    do_reset();
    do_cycle(1'b1, 4'b1001, 4'b0, 10'd0, 10'd0);
    wait_head_y(10);
    drain();
    check("miss_once", miss_seen, 1);
    check("miss_count", int'(row_count), 0);
`ifdef NOTE_HIGHWAY_SCORE_EN
    check("miss_total", int'(misses), 2);
`endif

    // Push, tick and retire in the same cycle with two rows held.
    do_reset();
    do_cycle(1'b1, 4'b0001, 4'b0, 10'd0, 10'd0);
    do_cycle(1'b1, 4'b0010, 4'b0, 10'd0, 10'd0);
    n = 0;
    while (!(m_q.size() > 0 && m_q[0].y == 10 && tcnt == TICK_DIV - 1) && n < 2000) begin
      idle();
      n++;
    end
    check("pr_reach", n < 2000 ? 1 : 0, 1);
    do_cycle(1'b1, 4'b0100, 4'b0, 10'd400, 10'd92);
    check("pr_count", int'(row_count), 2);
    query("pr_new_top", 400, 92, 4'b0100);
    query("pr_new_out", 400, 91, 4'b0000);
    query("pr_old_in", 200, 1, 4'b0010);
    query("pr_old_out", 200, 0, 4'b0000);

    // Asynchronous reset in the middle of scrolling.
    do_reset();
    do_cycle(1'b1, 4'b1111, 4'b0, 10'd0, 10'd0);
    repeat (20) idle();
    next_x = 10'd100;
    next_y = 10'd96;
    #5;
    rst_n = 1'b0;
    #1;
    check("rst_count", int'(row_count), 0);
    check("rst_ready", int'(push_ready), 1);
    check("rst_sprite", int'(sprite_pattern), 0);
    check("rst_hit", int'(hit_pulse), 0);
    check("rst_miss", int'(miss_pulse), 0);

    // Randomised traffic against the model.
    do_reset();
    repeat (900) begin
      do_cycle($urandom_range(0, 24) == 0, 4'($urandom_range(0, 15)),
               ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0,
               10'($urandom_range(0, 639)), Y_W'($urandom_range(0, 110)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
